// File: rtl/sevseg_pkg.sv
// Shared constants, shift FSM state type and segment-code decode helper for the
// seven-segment frame decoder.
package sevseg_pkg;

  localparam int FRAME_BITS = 8;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic {IDLE, SHIFT} shift_state_t;

  // Returns {legal, digit}; any code outside the ten digit glyphs is illegal.
  function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
    case (seg)
      SEG_0:   seg_to_bcd = {1'b1, 4'd0};
      SEG_1:   seg_to_bcd = {1'b1, 4'd1};
      SEG_2:   seg_to_bcd = {1'b1, 4'd2};
      SEG_3:   seg_to_bcd = {1'b1, 4'd3};
      SEG_4:   seg_to_bcd = {1'b1, 4'd4};
      SEG_5:   seg_to_bcd = {1'b1, 4'd5};
      SEG_6:   seg_to_bcd = {1'b1, 4'd6};
      SEG_7:   seg_to_bcd = {1'b1, 4'd7};
      SEG_8:   seg_to_bcd = {1'b1, 4'd8};
      SEG_9:   seg_to_bcd = {1'b1, 4'd9};
      default: seg_to_bcd = 5'b0;
    endcase
  endfunction

endpackage

// File: rtl/sevseg_frame_shifter.sv
// Serial-to-parallel front end: collects 8-bit MSB-first frames while sen is high
// and strobes frame_done the cycle after the 8th bit.
module sevseg_frame_shifter
  import sevseg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sdi,
  input  logic                  sen,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  shift_state_t          state, state_nx;
  logic [CNT_W-1:0]      count, count_nx;
  logic [FRAME_BITS-1:0] shreg, shreg_nx;
  logic                  done_nx;

  // Returning to IDLE after the last bit lets a following sen start the next frame immediately.
  always_comb begin
    state_nx = state;
    count_nx = count;
    shreg_nx = shreg;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (sen) begin
          shreg_nx = {shreg[FRAME_BITS-2:0], sdi};
          count_nx = CNT_W'(1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (sen) begin
          shreg_nx = {shreg[FRAME_BITS-2:0], sdi};
          if (count == CNT_W'(FRAME_BITS - 1)) begin
            done_nx  = 1'b1;
            count_nx = '0;
            state_nx = IDLE;
          end else begin
            count_nx = count + CNT_W'(1);
          end
        end else begin
          shreg_nx = '0;
          count_nx = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      shreg      <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      shreg      <= shreg_nx;
      frame_done <= done_nx;
      if (done_nx) frame <= shreg_nx;
    end
  end

endmodule

// File: rtl/sevenseg_frame_decoder.sv
// Seven-segment frame decoder: polarity inversion, frame-stability filter and
// illegal-pattern flag. Define SEVSEG_DEC_STICKY_ERR_EN to make err sticky until reset.
module sevenseg_frame_decoder
  import sevseg_pkg::*;
#(
  parameter int STABLE_FRAMES = 2,
  parameter int MATCH_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdi,
  input  logic       sen,
  input  logic       inv,
  output logic [3:0] digit,
  output logic       dp,
  output logic       valid,
  output logic       err,
  output logic       upd
);

  localparam logic [MATCH_W-1:0] STABLE = MATCH_W'(STABLE_FRAMES);

  logic [FRAME_BITS-1:0] frame, pat, last_pat;
  logic                  frame_done;
  logic [MATCH_W-1:0]    match_cnt, match_nx;
  logic [4:0]            dec;
  logic                  err_on_legal;

  sevseg_frame_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .sdi        (sdi),
    .sen        (sen),
    .frame      (frame),
    .frame_done (frame_done)
  );

  always_comb begin
    pat = frame ^ {FRAME_BITS{inv}};
    dec = seg_to_bcd(pat[6:0]);
    if (pat == last_pat)
      match_nx = (match_cnt >= STABLE) ? STABLE : match_cnt + MATCH_W'(1);
    else
      match_nx = MATCH_W'(1);
`ifdef SEVSEG_DEC_STICKY_ERR_EN
    err_on_legal = err;
`else
    err_on_legal = 1'b0;
`endif
  end

  // Illegal frames still update the match history so a glitch breaks a stable run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit     <= '0;
      dp        <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      upd       <= 1'b0;
      match_cnt <= '0;
      last_pat  <= '0;
    end else begin
      upd <= 1'b0;
      if (frame_done) begin
        last_pat  <= pat;
        match_cnt <= match_nx;
        if (dec[4]) begin
          err <= err_on_legal;
          if (match_nx == STABLE) begin
            digit <= dec[3:0];
            dp    <= pat[7];
            valid <= 1'b1;
            upd   <= 1'b1;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_frame_decoder.sv
// Scoreboard bench for sevenseg_frame_decoder: drives one stimulus stream into a
// STABLE_FRAMES=2 and a STABLE_FRAMES=1 instance and checks both against a model.
module tb_sevenseg_frame_decoder;

  typedef struct packed {
    logic [3:0] digit;
    logic       dp;
    logic       valid;
    logic       err;
    logic       upd;
  } outs_t;

  typedef struct {
    int    due;
    outs_t o0;
    outs_t o1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sdi = 1'b0;
  logic sen = 1'b0;
  logic inv = 1'b0;

  logic [3:0] digit0, digit1;
  logic dp0, valid0, err0, upd0;
  logic dp1, valid1, err1, upd1;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  exp_t       sb[$];
  logic [7:0] m_last[2];
  int         m_match[2];
  outs_t      m_out[2];
  int         stab[2] = '{2, 1};
  int         exp_upd[2] = '{0, 0};
  int         seen_upd[2] = '{0, 0};
  logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  sevenseg_frame_decoder #(.STABLE_FRAMES(2), .MATCH_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sen(sen), .inv(inv),
    .digit(digit0), .dp(dp0), .valid(valid0), .err(err0), .upd(upd0)
  );

  sevenseg_frame_decoder #(.STABLE_FRAMES(1), .MATCH_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sen(sen), .inv(inv),
    .digit(digit1), .dp(dp1), .valid(valid1), .err(err1), .upd(upd1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else
      passes++;
  endtask

  task automatic compareOuts(input string pre, input outs_t got, input outs_t exp);
    checkOutput({pre, ".digit"}, 32'(got.digit), 32'(exp.digit));
    checkOutput({pre, ".dp"},    32'(got.dp),    32'(exp.dp));
    checkOutput({pre, ".valid"}, 32'(got.valid), 32'(exp.valid));
    checkOutput({pre, ".err"},   32'(got.err),   32'(exp.err));
    checkOutput({pre, ".upd"},   32'(got.upd),   32'(exp.upd));
  endtask

  task automatic modelReset();
    for (int j = 0; j < 2; j++) begin
      m_last[j]  = 8'h00;
      m_match[j] = 0;
      m_out[j]   = '0;
    end
    sb.delete();
  endtask

  task automatic modelStep(input int j, input logic [7:0] f);
    logic [7:0] p;
    int idx;
    p = f ^ {8{inv}};
    if (p == m_last[j])
      m_match[j] = (m_match[j] >= stab[j]) ? stab[j] : m_match[j] + 1;
    else
      m_match[j] = 1;
    m_last[j] = p;
    idx = -1;
    for (int k = 0; k < 10; k++)
      if (seg_tab[k] == p[6:0]) idx = k;
    m_out[j].upd = 1'b0;
    if (idx >= 0) begin
`ifndef SEVSEG_DEC_STICKY_ERR_EN
      m_out[j].err = 1'b0;
`endif
      if (m_match[j] == stab[j]) begin
        m_out[j].digit = idx[3:0];
        m_out[j].dp    = p[7];
        m_out[j].valid = 1'b1;
        m_out[j].upd   = 1'b1;
        exp_upd[j]++;
      end
    end else begin
      m_out[j].err = 1'b1;
    end
  endtask

  // Full frame: the 8th bit is sampled at edge cyc+1, results visible after edge cyc+2.
  task automatic applyStimulus(input logic [7:0] f);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = f[7-i];
    end
    modelStep(0, f);
    modelStep(1, f);
    e.due = cyc + 2;
    e.o0  = m_out[0];
    e.o1  = m_out[1];
    sb.push_back(e);
  endtask

  task automatic sendPartial(input logic [7:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = f[7-i];
    end
    @(negedge clk);
    sen = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sdi = 1'b0;
    end
  endtask

  task automatic setInv(input logic v);
    idle(1);
    @(negedge clk);
    sen = 1'b0;
    inv = v;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (upd0) seen_upd[0]++;
    if (upd1) seen_upd[1]++;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("sb.due", 32'(cyc), 32'(e.due));
      compareOuts("s2", {digit0, dp0, valid0, err0, upd0}, e.o0);
      compareOuts("s1", {digit1, dp1, valid1, err1, upd1}, e.o1);
    end
  end

  initial begin
    logic [7:0] f;
    modelReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compareOuts("rst2", {digit0, dp0, valid0, err0, upd0}, '0);
    compareOuts("rst1", {digit1, dp1, valid1, err1, upd1}, '0);
    rst_n = 1'b1;

    applyStimulus(8'h3F);
    applyStimulus(8'h3F);
    idle(2);

    setInv(1'b1);
    applyStimulus(8'hF9);
    applyStimulus(8'hF9);
    idle(1);
    applyStimulus(8'h12);
    applyStimulus(8'h12);
    idle(1);
    setInv(1'b0);

    applyStimulus(8'h77);
    idle(1);
    applyStimulus(8'h4F);
    idle(2);

    sendPartial(8'hFF, 5);
    applyStimulus(8'h4F);
    applyStimulus(8'h4F);
    idle(2);

    applyStimulus(8'h06);
    applyStimulus(8'h5B);
    applyStimulus(8'h06);
    idle(3);
    checkOutput("upd.count2", 32'(seen_upd[0]), 32'(exp_upd[0]));
    checkOutput("upd.count1", 32'(seen_upd[1]), 32'(exp_upd[1]));

    // Reset asserted while the 6th bit of a frame is on the wire.
    f = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sen = 1'b1;
      sdi = f[7-i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    sdi = f[2];
    modelReset();
    @(negedge clk);
    sen = 1'b0;
    sdi = 1'b0;
    compareOuts("midrst2", {digit0, dp0, valid0, err0, upd0}, '0);
    compareOuts("midrst1", {digit1, dp1, valid1, err1, upd1}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    applyStimulus(8'h7F);
    applyStimulus(8'h7F);
    idle(2);

    for (int blk = 0; blk < 12; blk++) begin
      setInv(1'($urandom_range(0, 1)));
      f = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 9)]};
      if ($urandom_range(0, 4) == 0) f = 8'($urandom_range(0, 255));
      if (inv) f = ~f;
      for (int r = 0; r < int'($urandom_range(1, 3)); r++)
        applyStimulus(f);
      idle(1);
    end

    idle(4);
    checkOutput("sb.empty", 32'(sb.size()), 32'd0);
    checkOutput("upd.total2", 32'(seen_upd[0]), 32'(exp_upd[0]));
    checkOutput("upd.total1", 32'(seen_upd[1]), 32'(exp_upd[1]));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
